// File: rtl/block_reader_pkg.sv
// Shared types and defaults for the block reader and its RAM interface.
package block_reader_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 10;
  localparam int unsigned BLK_DEF        = 8;

  // Downstream sample payload: data plus its valid flag.
  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      load;
  } in_t;

  // Index width helper that never returns zero, so degenerate depths still elaborate.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_if.sv
// Read port of a synchronous single-cycle-latency sample RAM.
interface ram_if
  import block_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = BLK_DEF * BLK_DEF
);
  localparam int unsigned AW = clog2_min1(DEPTH);

  logic [AW-1:0]         addr;
  logic                  en;
  logic [DATA_WIDTH-1:0] data;

  modport RdRx (output addr, output en, input data);
  modport RdTx (input addr, input en, output data);
endinterface

// File: rtl/block_reader_skid_fifo2.sv
// Two-entry skid FIFO absorbing RAM returns while downstream stalls.
module skid_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         push_ok_c;
  logic         pop_ok_c;

  // Push is refused only when full and not popping; pop needs a stored entry.
  always_comb begin
    push_ok_c = push_i && ((cnt_q != 2'd2) || pop_i);
    pop_ok_c  = pop_i && (cnt_q != 2'd0);
  end

  // Storage, pointers and occupancy; simultaneous push and pop keep occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok_c) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_ok_c) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + 2'(push_ok_c) - 2'(pop_ok_c);
    end
  end

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/block_reader.sv
// Streams one BLK x BLK block out of a synchronous RAM, row- or column-major,
// with credit-limited reads into a 2-entry skid FIFO.
module block_reader
  import block_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned BLK        = BLK_DEF,
  parameter int unsigned TRANSPOSE  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  ram_if.RdRx                   ram,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outLoad,
  input  logic                  outReady,
  output logic                  outLast,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned N  = BLK * BLK;
  localparam int unsigned IW = clog2_min1(N);

  // The attached RAM must hold exactly one block.
  if (ram.DEPTH != BLK * BLK) begin : g_depth_chk
    $error("block_reader: ram_if DEPTH must equal BLK*BLK");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] xfer_q, xfer_d;
  logic          infl_q;
  logic          busy_q;
  logic          done_q;

  logic [IW-1:0] row_c, col_c, addr_c;
  logic [2:0]    occ_c;
  logic [2:0]    occ_eff_c;
  logic          en_c;
  logic          pop_c;
  logic          last_c;
  logic          fifo_full;
  logic          fifo_empty;

  // Read address in row- or column-major order.
  always_comb begin
    row_c = IW'(idx_q / BLK);
    col_c = IW'(idx_q % BLK);
    if (TRANSPOSE != 0) begin
      addr_c = IW'(col_c * BLK + row_c);
    end else begin
      addr_c = idx_q;
    end
  end

  // Read credit: buffered + in-flight samples after this cycle's pop must stay below 2.
  always_comb begin
    pop_c     = !fifo_empty && outReady;
    occ_c     = fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1);
    occ_eff_c = occ_c + 3'(infl_q) - 3'(pop_c);
    en_c      = (state_q == READ) && (occ_eff_c < 3'd2);
    last_c    = !fifo_empty && (xfer_q == IW'(N - 1));
  end

  // Next-state logic for the FSM, read index and transfer counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xfer_d  = xfer_q;
    if (pop_c) begin
      xfer_d = (xfer_q == IW'(N - 1)) ? '0 : xfer_q + IW'(1);
    end
    case (state_q)
      IDLE: begin
        if (start) state_d = READ;
      end
      READ: begin
        if (en_c) begin
          if (idx_q == IW'(N - 1)) begin
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      DRAIN: begin
        if (pop_c && last_c) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      xfer_q  <= '0;
      infl_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      xfer_q  <= xfer_d;
      infl_q  <= en_c;
      busy_q  <= (state_d == READ) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
    end
  end

  skid_fifo2 #(
    .W (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (infl_q),
    .data_i  (ram.data),
    .pop_i   (pop_c),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (outData)
  );

  assign ram.en   = en_c;
  assign ram.addr = addr_c;
  assign outLoad  = !fifo_empty;
  assign outLast  = last_c;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_block_reader.sv
// Bench for block_reader: one row-major and one column-major instance share
// stimulus; a monitor compares both streams against a block-order model.
module tb_block_reader;

  localparam int unsigned DW  = 10;
  localparam int unsigned B   = 8;
  localparam int unsigned NS  = B * B;

  logic clk;
  logic rst_n;
  logic start;
  logic outReady;

  logic [DW-1:0] out_data0, out_data1;
  logic          out_load0, out_load1;
  logic          out_last0, out_last1;
  logic          busy0, busy1;
  logic          done0, done1;

  ram_if #(.DATA_WIDTH(DW), .DEPTH(NS)) rif0 ();
  ram_if #(.DATA_WIDTH(DW), .DEPTH(NS)) rif1 ();

  block_reader #(.DATA_WIDTH(DW), .BLK(B), .TRANSPOSE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .ram(rif0),
    .outData(out_data0), .outLoad(out_load0), .outReady(outReady),
    .outLast(out_last0), .busy(busy0), .done(done0)
  );

  block_reader #(.DATA_WIDTH(DW), .BLK(B), .TRANSPOSE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .ram(rif1),
    .outData(out_data1), .outLoad(out_load1), .outReady(outReady),
    .outLast(out_last1), .busy(busy1), .done(done1)
  );

  logic [DW-1:0] ram_mem [NS];

  // Synchronous RAMs, one cycle read latency.
  always @(posedge clk) if (rif0.en) rif0.data <= ram_mem[rif0.addr];
  always @(posedge clk) if (rif1.en) rif1.data <= ram_mem[rif1.addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // k-th sample of a block: row-major reads address k, column-major walks
  // down each column first, i.e. element (row=k%B, col=k/B) of the block.
  function automatic logic [DW-1:0] model_sample(input int inst, input int kk);
    int a;
    a = (inst == 0) ? kk : (kk % B) * B + kk / B;
    return ram_mem[a];
  endfunction

  // Shared state between the scenario and the monitor.
  int  ready_mode;
  int  stall_left;
  int  k     [2];
  int  outst [2];
  int  dones [2];
  bit  seen  [2][NS];
  bit  stall_prev [2];
  bit  done_due   [2];
  logic [DW-1:0] pdata [2];
  logic          plast [2];

  logic          ld [2], lst [2], dn [2], bz [2], en [2];
  logic [DW-1:0] dat [2];
  logic [5:0]    ad [2];

  // Monitor: checks outputs at the falling edge, then chooses outReady.
  initial begin
    int cyc;
    bit r;
    int pop;
    cyc = 0;
    outReady = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          k[i] = 0; outst[i] = 0; stall_prev[i] = 0; done_due[i] = 0;
        end
        outReady = 1'b1;
      end else begin
        ld[0] = out_load0; ld[1] = out_load1;
        lst[0] = out_last0; lst[1] = out_last1;
        dn[0] = done0; dn[1] = done1;
        bz[0] = busy0; bz[1] = busy1;
        dat[0] = out_data0; dat[1] = out_data1;
        for (int i = 0; i < 2; i++) begin
          if (dn[i] || done_due[i]) chk($sformatf("done_pulse%0d", i), 32'(dn[i]), 32'(done_due[i]));
          if (dn[i]) begin
            dones[i]++;
            chk($sformatf("busy_in_done%0d", i), 32'(bz[i]), 0);
          end
          if (stall_prev[i]) begin
            chk($sformatf("stall_load%0d", i), 32'(ld[i]), 1);
            chk($sformatf("stall_data%0d", i), 32'(dat[i]), 32'(pdata[i]));
            chk($sformatf("stall_last%0d", i), 32'(lst[i]), 32'(plast[i]));
          end
          if (ld[i]) begin
            if (k[i] >= NS) chk($sformatf("extra_sample%0d", i), 32'(k[i]), NS - 1);
            else begin
              chk($sformatf("data%0d_k%0d", i, k[i]), 32'(dat[i]), 32'(model_sample(i, k[i])));
              chk($sformatf("last%0d_k%0d", i, k[i]), 32'(lst[i]), 32'(k[i] == NS - 1));
            end
          end
        end
        case (ready_mode)
          1:       r = cyc[0];
          2: begin
            if (k[0] == 10 && stall_left > 0) begin
              r = 1'b0;
              stall_left--;
            end else r = 1'b1;
          end
          3:       r = 1'($urandom_range(0, 1));
          default: r = 1'b1;
        endcase
        outReady = r;
        cyc++;
        #1;
        en[0] = rif0.en; en[1] = rif1.en;
        ad[0] = rif0.addr; ad[1] = rif1.addr;
        for (int i = 0; i < 2; i++) begin
          pop = (ld[i] && r) ? 1 : 0;
          if (en[i]) begin
            chk($sformatf("en_busy%0d", i), 32'(bz[i]), 1);
            chk($sformatf("en_credit%0d", i), 32'((outst[i] - pop) < 2), 1);
            chk($sformatf("addr_dup%0d_a%0d", i, ad[i]), 32'(seen[i][ad[i]]), 0);
            seen[i][ad[i]] = 1'b1;
          end
          outst[i] += (en[i] ? 1 : 0) - pop;
          chk($sformatf("outstanding%0d", i), 32'(outst[i] <= 2), 1);
          stall_prev[i] = ld[i] && !r;
          pdata[i] = dat[i];
          plast[i] = lst[i];
          done_due[i] = (pop == 1) && (k[i] == NS - 1);
          if (pop == 1) k[i]++;
        end
      end
    end
  end

  typedef struct {
    int ram_mode;       // 0: RAM[i]=i, 1: random contents
    int ready_mode;     // 0: always, 1: toggle, 2: long stall at 10, 3: random
    int start_at;       // extra start pulse at this sample, -1 none
    int rst_at;         // reset at this sample, -1 none
    bit start_in_done;  // raise start during the done cycle
    int exp_lat;        // edges from start-sampling edge to first outLoad
    int exp_span;       // edges from first outLoad to done, 0 = unchecked
    int exp_dones;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_load0"}, 32'(out_load0), 0); chk({tag, "_load1"}, 32'(out_load1), 0);
    chk({tag, "_last0"}, 32'(out_last0), 0); chk({tag, "_last1"}, 32'(out_last1), 0);
    chk({tag, "_busy0"}, 32'(busy0), 0);     chk({tag, "_busy1"}, 32'(busy1), 0);
    chk({tag, "_done0"}, 32'(done0), 0);     chk({tag, "_done1"}, 32'(done1), 0);
    chk({tag, "_en0"}, 32'(rif0.en), 0);     chk({tag, "_en1"}, 32'(rif1.en), 0);
    chk({tag, "_addr0"}, 32'(rif0.addr), 0); chk({tag, "_addr1"}, 32'(rif1.addr), 0);
    chk({tag, "_data0"}, 32'(out_data0), 0); chk({tag, "_data1"}, 32'(out_data1), 0);
  endtask

  task automatic run_block(input int vi, input vec_t v);
    int lat;
    int n;
    bit pulsed;
    for (int i = 0; i < NS; i++) ram_mem[i] = (v.ram_mode == 0) ? DW'(i) : DW'($urandom);
    for (int i = 0; i < 2; i++) begin
      dones[i] = 0; k[i] = 0;
      for (int a = 0; a < NS; a++) seen[i][a] = 1'b0;
    end
    ready_mode = v.ready_mode;
    stall_left = 20;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!out_load0 && lat < 50) begin
      step();
      lat++;
    end
    chk($sformatf("v%0d_latency", vi), 32'(lat), 32'(v.exp_lat));
    n = 0;
    pulsed = 0;
    while (!done0 && n < 2000 && !(v.rst_at >= 0 && k[0] >= v.rst_at)) begin
      if (v.start_at >= 0 && !pulsed && k[0] >= v.start_at) begin
        start = 1'b1;
        pulsed = 1;
      end else start = 1'b0;
      step();
      n++;
    end
    start = 1'b0;
    if (v.rst_at >= 0) begin
      chk($sformatf("v%0d_reached_rst_point", vi), 32'(k[0] >= v.rst_at), 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs($sformatf("v%0d_midrst", vi));
      step();
      step();
      rst_n = 1'b1;
      step();
      chk($sformatf("v%0d_idle_after_rst", vi), 32'(busy0 | busy1 | out_load0 | out_load1), 0);
      return;
    end
    chk($sformatf("v%0d_done_seen", vi), 32'(done0), 1);
    if (v.exp_span != 0) chk($sformatf("v%0d_span", vi), 32'(n), 32'(v.exp_span));
    if (v.start_in_done) begin
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk($sformatf("v%0d_done_start_ignored0", vi), 32'(busy0), 0);
      chk($sformatf("v%0d_done_start_ignored1", vi), 32'(busy1), 0);
    end
    repeat (4) step();
    chk($sformatf("v%0d_count0", vi), 32'(k[0]), NS);
    chk($sformatf("v%0d_count1", vi), 32'(k[1]), NS);
    chk($sformatf("v%0d_dones0", vi), 32'(dones[0]), 32'(v.exp_dones));
    chk($sformatf("v%0d_dones1", vi), 32'(dones[1]), 32'(v.exp_dones));
    chk($sformatf("v%0d_idle", vi), 32'(busy0 | busy1 | out_load0 | out_load1), 0);
  endtask

  vec_t vecs [9];

  initial begin
    //              ram rdy start rst  sid lat span dones
    vecs[0] = '{0, 0, -1, -1, 1'b0, 2, 64, 1};  // row-major / transpose streaming
    vecs[1] = '{0, 1, -1, -1, 1'b0, 2, 0,  1};  // 1/0 backpressure
    vecs[2] = '{0, 2, -1, -1, 1'b0, 2, 0,  1};  // long stall at sample 10
    vecs[3] = '{0, 0, 30, -1, 1'b1, 2, 64, 1};  // start while busy, start in done
    vecs[4] = '{1, 3, -1, -1, 1'b0, 2, 0,  1};  // random data, random ready
    vecs[5] = '{1, 3, 20, -1, 1'b0, 2, 0,  1};
    vecs[6] = '{1, 1, -1, -1, 1'b0, 2, 0,  1};
    vecs[7] = '{0, 0, -1, 40, 1'b0, 2, 0,  0};  // reset mid-block at sample 40
    vecs[8] = '{0, 0, -1, -1, 1'b0, 2, 64, 1};  // clean restart from index 0

    rst_n = 1'b0;
    start = 1'b0;
    ready_mode = 0;
    stall_left = 0;
    for (int i = 0; i < NS; i++) ram_mem[i] = DW'(i);
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();
    step();
    chk("idle_busy", 32'(busy0 | busy1), 0);

    for (int vi = 0; vi < 9; vi++) run_block(vi, vecs[vi]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
